// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the integer pipeline and muldiv_unit.
// The pipeline drives the request side (master); the unit drives the response side (slave).
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, a, b, kill, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, a, b, kill, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one radix-2 step per cycle on operand magnitudes,
// with sign correction applied when the final step is loaded into the result register.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   divisor_q;
  logic [2*XLEN-1:0] acc;
  logic              neg_main, neg_rem;
  logic [XLEN-1:0]   result_q;

  logic              accept, last_step;
  logic              signed_a, signed_b, neg_a, neg_b;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   mag_a, mag_b, special_val;
  logic [XLEN:0]     mul_sum, div_shift, div_rem;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next, step_next, prod_signed;
  logic [XLEN-1:0]   quo, rem, final_val;

  assign accept    = bus.in_valid & (state == IDLE) & ~bus.kill;
  assign last_step = (cnt == CW'(XLEN - 1));

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (bus.op)
      3'b000, 3'b001, 3'b100, 3'b110: begin signed_a = 1'b1; signed_b = 1'b1; end
      3'b010:                         signed_a = 1'b1;
      default:                        ;
    endcase
  end

  assign neg_a    = signed_a & bus.a[XLEN-1];
  assign neg_b    = signed_b & bus.b[XLEN-1];
  assign mag_a    = neg_a ? -bus.a : bus.a;
  assign mag_b    = neg_b ? -bus.b : bus.b;
  assign div_zero = bus.op[2] & (bus.b == '0);
  assign div_ovf  = bus.op[2] & ~bus.op[0] & (bus.a == INT_MIN) & (bus.b == '1);
  assign special  = div_zero | div_ovf;

  // op[1] separates quotient (DIV/DIVU) from remainder (REM/REMU) forms
  always_comb begin
    special_val = '0;
    if (div_zero)
      special_val = bus.op[1] ? bus.a : '1;
    else if (div_ovf)
      special_val = bus.op[1] ? '0 : bus.a;
  end

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor_q} : '0);
  assign mul_next  = {mul_sum, acc[XLEN-1:1]};
  assign div_shift = acc[2*XLEN-1:XLEN-1];
  assign div_ge    = (div_shift >= {1'b0, divisor_q});
  assign div_rem   = div_ge ? (div_shift - {1'b0, divisor_q}) : div_shift;
  assign div_next  = {div_rem[XLEN-1:0], acc[XLEN-2:0], div_ge};
  assign step_next = op_q[2] ? div_next : mul_next;

  assign prod_signed = neg_main ? -step_next : step_next;
  assign quo         = step_next[XLEN-1:0];
  assign rem         = step_next[2*XLEN-1:XLEN];

  always_comb begin
    final_val = '0;
    case (op_q)
      3'b000:                 final_val = prod_signed[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod_signed[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_val = neg_main ? -quo : quo;
      default:                final_val = neg_rem ? -rem : rem;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: if (last_step) state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.kill) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      divisor_q <= '0;
      acc       <= '0;
      neg_main  <= 1'b0;
      neg_rem   <= 1'b0;
      result_q  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt       <= '0;
        op_q      <= bus.op;
        divisor_q <= mag_b;
        acc       <= {{XLEN{1'b0}}, mag_a};
        neg_main  <= neg_a ^ neg_b;
        neg_rem   <= neg_a;
        if (special) result_q <= special_val;
      end else if (state == CALC && !bus.kill) begin
        acc <= step_next;
        cnt <= cnt + 1'b1;
        if (last_step) result_q <= final_val;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
endmodule
